uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_parity.sv | 12 +
 rtl/uart_tx.sv | 136 +++++++++++++
 tb/tb_uart_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and serial line levels, used by both Tx and Rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Bits needed to count 0..range-1, never less than one bit.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity of the latched Tx word; i_parity_type=1 selects odd parity.
module uart_tx_parity #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_parity_type,
  output logic                  o_parity
);

  assign o_parity = (^i_data) ^ i_parity_type;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to add the parity_type port and the parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
`ifdef UART_TX_PARITY_EN
  input  logic                  parity_type,
`endif
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shadow;
  logic                  w_bit_done;
  logic [IDX_W-1:0]      w_next_idx;

  assign w_bit_done = (r_cnt == CNT_LAST);
  assign w_next_idx = r_bit_idx + 1'b1;

`ifdef UART_TX_PARITY_EN
  logic r_parity_type;
  logic w_parity;

  uart_tx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .i_data        (r_shadow),
    .i_parity_type (r_parity_type),
    .o_parity      (w_parity)
  );
`endif

  // Outputs are loaded with the level of the state being entered, so each level lasts CLKS_PER_BIT cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shadow  <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity_type <= 1'b0;
`endif
      tx_out    <= IDLE_LEVEL;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          tx_out    <= IDLE_LEVEL;
          busy      <= 1'b0;
          if (data_valid) begin
            r_shadow <= data_in;
`ifdef UART_TX_PARITY_EN
            r_parity_type <= parity_type;
`endif
            r_state  <= START;
            tx_out   <= START_LEVEL;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_state <= DATA;
            tx_out  <= r_shadow[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_bit_idx == IDX_LAST) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= PARITY;
              tx_out    <= w_parity;
`else
              r_state   <= STOP;
              tx_out    <= STOP_LEVEL;
`endif
            end else begin
              r_bit_idx <= w_next_idx;
              tx_out    <= r_shadow[w_next_idx];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_state <= STOP;
            tx_out  <= STOP_LEVEL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            tx_out  <= IDLE_LEVEL;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_bit_idx <= '0;
          tx_out    <= IDLE_LEVEL;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (CLKS_PER_BIT=4) with a queue of expected frames checked bit by bit.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME_BITS = 2 + DW + PBITS;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ptype;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          parity_type = 1'b0;
  logic          tx_out;
  logic          busy;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
`ifdef UART_TX_PARITY_EN
    .parity_type (parity_type),
`endif
    .tx_out      (tx_out),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), 32'(tx_out), 32'(1));
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'(0));
      tick();
    end
  endtask

  // Drive one request; it is sampled at the next edge. hold keeps data_valid high afterwards.
  task automatic start_frame(input logic [DW-1:0] d, input logic pt, input bit hold);
    data_in     = d;
    parity_type = pt;
    data_valid  = 1'b1;
    sb_q.push_back('{data: d, ptype: pt});
    tick();
    if (!hold) data_valid = 1'b0;
  endtask

  // Entered just after the edge that accepted the request; checks every cycle of the frame.
  task automatic check_frame(input string tag, input int inject_at);
    exp_t                  e;
    logic [FRAME_BITS-1:0] bits;
    int                    k;
    int                    ones;
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'(1));
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    bits[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DW; i++) begin
      bits[1+i] = e.data[i];
      if (e.data[i]) ones++;
    end
`ifdef UART_TX_PARITY_EN
    bits[DW+1] = (ones % 2 == 1) ^ e.ptype;
`endif
    bits[FRAME_BITS-1] = 1'b1;
    k = 0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("%s_bit%0d_c%0d", tag, b, c), 32'(tx_out), 32'(bits[b]));
        chk($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'(1));
        if (k == inject_at) begin
          data_in    = 8'hFF;
          data_valid = 1'b1;
        end
        tick();
        if (k == inject_at) data_valid = 1'b0;
        k++;
      end
    end
    chk({tag, "_end_tx"}, 32'(tx_out), 32'(1));
    chk({tag, "_end_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_tx", 32'(tx_out), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    reset = 1'b1;
    tick();

    // Long idle with no requests
    idle_check("idle", 100);

    // Plain frames with distinct patterns
    start_frame(8'hA5, 1'b0, 1'b0);
    check_frame("a5", -1);
    idle_check("gap1", 2);
    start_frame(8'h3C, 1'b0, 1'b0);
    check_frame("3c", -1);
    start_frame(8'h01, 1'b0, 1'b0);
    check_frame("01", -1);
    start_frame(8'h80, 1'b0, 1'b0);
    check_frame("80", -1);

    // Request in the middle of a frame is ignored
    start_frame(8'hA5, 1'b0, 1'b0);
    check_frame("ign", 10);
    idle_check("nosecond", 20);

    // Back-to-back: data_valid held high across two frames
    start_frame(8'h00, 1'b0, 1'b1);
    data_in = 8'hFF;
    sb_q.push_back('{data: 8'hFF, ptype: 1'b0});
    check_frame("b2b0", -1);
    tick();
    data_valid = 1'b0;
    check_frame("b2b1", -1);
    idle_check("b2b_after", 3);

`ifdef UART_TX_PARITY_EN
    start_frame(8'hA5, 1'b0, 1'b0);
    check_frame("par_even", -1);
    start_frame(8'hA5, 1'b1, 1'b0);
    check_frame("par_odd", -1);
`endif

    // Reset asserted during data bit 3
    start_frame(8'h3C, 1'b0, 1'b0);
    repeat (CPB + 3 * CPB + 2) tick();
    chk("mid_busy", 32'(busy), 32'(1));
    reset = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx_out), 32'(1));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    sb_q.delete();
    tick();
    tick();
    reset = 1'b1;
    idle_check("post_rst", 3);
    start_frame(8'h3C, 1'b0, 1'b0);
    check_frame("after_rst", -1);
    idle_check("final", 5);

    chk("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
